// File: rtl/ddr_pkg.sv
// Shared types for the DDR host-port arbiter.
// Controller command encodings and arbiter FSM states.
package ddr_pkg;

    typedef enum logic [2:0] {
        NOP       = 3'b000,
        READA     = 3'b001,
        WRITEA    = 3'b010,
        REFRESH   = 3'b011,
        PRECHARGE = 3'b100,
        LOAD_MODE = 3'b101,
        LOAD_REG1 = 3'b110,
        LOAD_REG2 = 3'b111
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        CMD_ISSUE,
        WR_DATA,
        RD_WAIT,
        RD_DATA,
        REF_ISSUE,
        DONE
    } arb_state_e;

endpackage

// File: rtl/ddr_rr_arbiter.sv
// Round-robin pick: first valid requester at or after the pointer.
// Purely combinational; one-hot grant plus encoded index.
module ddr_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               found
);

    logic [PTR_W-1:0] idx;

    // Walk from the farthest offset down so the nearest valid one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (req_valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr_host_arbiter.sv
// Shares the DDR controller host command port between requesters,
// sequencing data windows and inserting periodic auto-refresh.
module ddr_host_arbiter
    import ddr_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 128,
    parameter int BURST_LEN  = 2,
    parameter int RD_LAT     = 4,
    parameter int REF_PERIOD = 1560
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [3*NUM_REQ-1:0]        req_cmd,
    input  logic [ADDR_W*NUM_REQ-1:0]   req_addr,
    input  logic [DATA_W*NUM_REQ-1:0]   req_wdata,
    input  logic [DATA_W/8*NUM_REQ-1:0] req_dm,
    output logic [NUM_REQ-1:0]          wdata_pop,
    output logic [DATA_W-1:0]           rd_data,
    output logic [NUM_REQ-1:0]          rd_valid,
    output logic [2:0]                  CMD,
    output logic [ADDR_W-1:0]           ADDR,
    input  logic                        CMDACK,
    output logic [DATA_W-1:0]           DATAIN,
    output logic [DATA_W/8-1:0]         DM,
    input  logic [DATA_W-1:0]           DATAOUT,
    output logic                        busy,
    output logic                        ref_overrun
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int MW    = DATA_W / 8;

    arb_state_e         state, state_n;
    logic [PTR_W-1:0]   owner_q, rr_ptr, grant_idx;
    logic [NUM_REQ-1:0] grant, owner_oh;
    cmd_e               cmd_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               is_ref, found, take, legal;
    logic [2:0]         pick_cmd;
    logic [7:0]         cnt;
    logic [15:0]        ref_cnt;
    logic               ref_pending;

    ddr_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .found     (found)
    );

    assign pick_cmd = req_cmd[grant_idx*3 +: 3];
    assign legal    = (pick_cmd == READA) || (pick_cmd == WRITEA);
    assign take     = (state == IDLE) && !ref_pending && found;
    assign owner_oh = NUM_REQ'(1) << owner_q;
    assign busy     = (state != IDLE);

    always_comb begin
        state_n   = state;
        CMD       = NOP;
        ADDR      = '0;
        DATAIN    = '0;
        DM        = '0;
        wdata_pop = '0;
        case (state)
            IDLE: begin
                if (ref_pending)
                    state_n = REF_ISSUE;
                else if (found)
                    state_n = legal ? CMD_ISSUE : DONE;
            end
            CMD_ISSUE: begin
                CMD  = cmd_q;
                ADDR = addr_q;
                if (CMDACK)
                    state_n = (cmd_q == WRITEA) ? WR_DATA : RD_WAIT;
            end
            WR_DATA: begin
                DATAIN    = req_wdata[owner_q*DATA_W +: DATA_W];
                DM        = req_dm[owner_q*MW +: MW];
                wdata_pop = owner_oh;
                if (cnt == 8'(BURST_LEN - 1))
                    state_n = DONE;
            end
            RD_WAIT: begin
                if (cnt == 8'(RD_LAT - 2))
                    state_n = RD_DATA;
            end
            RD_DATA: begin
                if (cnt == 8'(BURST_LEN - 1))
                    state_n = DONE;
            end
            REF_ISSUE: begin
                CMD = REFRESH;
                if (CMDACK)
                    state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            owner_q     <= '0;
            cmd_q       <= NOP;
            addr_q      <= '0;
            is_ref      <= 1'b0;
            rr_ptr      <= '0;
            cnt         <= '0;
            ref_cnt     <= 16'(REF_PERIOD - 1);
            ref_pending <= 1'b0;
            ref_overrun <= 1'b0;
            req_ready   <= '0;
            rd_data     <= '0;
            rd_valid    <= '0;
        end else begin
            state     <= state_n;
            cnt       <= (state_n != state) ? 8'd0 : cnt + 8'd1;
            req_ready <= take ? grant : '0;
            if (take) begin
                owner_q <= grant_idx;
                cmd_q   <= cmd_e'(pick_cmd);
                addr_q  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                is_ref  <= 1'b0;
            end else if (state == IDLE && ref_pending) begin
                is_ref <= 1'b1;
            end
            if (state == DONE && !is_ref)
                rr_ptr <= (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
            rd_valid <= (state == RD_DATA) ? owner_oh : '0;
            if (state == RD_DATA)
                rd_data <= DATAOUT;
            // Expiry beats a same-cycle acknowledge so no interval is lost.
            if (ref_cnt == 16'd0) begin
                ref_cnt     <= 16'(REF_PERIOD - 1);
                ref_pending <= 1'b1;
                if (ref_pending)
                    ref_overrun <= 1'b1;
            end else begin
                ref_cnt <= ref_cnt - 16'd1;
                if (state == REF_ISSUE && CMDACK)
                    ref_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ddr_host_arbiter.sv
// Directed bench for ddr_host_arbiter: write, read, illegal command,
// round robin, refresh insertion, overrun and asynchronous reset.
module tb_ddr_host_arbiter;

    localparam int N  = 2;
    localparam int AW = 23;
    localparam int DW = 128;
    localparam int MW = DW / 8;

    localparam logic [DW-1:0] B0 = 128'hA5A5_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [DW-1:0] B1 = 128'hA5A5_0000_0000_0000_0000_0000_0000_0002;
    localparam logic [DW-1:0] BX = 128'h7777_0000_0000_0000_0000_0000_0000_0009;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready, wdata_pop, rd_valid;
    logic [3*N-1:0]  req_cmd;
    logic [AW*N-1:0] req_addr;
    logic [DW*N-1:0] req_wdata;
    logic [MW*N-1:0] req_dm;
    logic [DW-1:0]   rd_data, datain, dataout;
    logic [2:0]      cmd;
    logic [AW-1:0]   addr;
    logic            cmdack, busy, ref_overrun;
    logic [MW-1:0]   dm;

    logic            r_rst_n;
    logic [N-1:0]    r_req_valid, r_req_ready, r_wdata_pop, r_rd_valid;
    logic [3*N-1:0]  r_req_cmd;
    logic [AW*N-1:0] r_req_addr;
    logic [DW*N-1:0] r_req_wdata;
    logic [MW*N-1:0] r_req_dm;
    logic [DW-1:0]   r_rd_data, r_datain, r_dataout;
    logic [2:0]      r_cmd;
    logic [AW-1:0]   r_addr;
    logic            r_cmdack, r_busy, r_ref_overrun;
    logic [MW-1:0]   r_dm;

    int n_cmp  = 0;
    int n_fail = 0;

    ddr_host_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW),
        .BURST_LEN(2), .RD_LAT(4), .REF_PERIOD(1000)
    ) u_dut (
        .CLK(clk), .RESET_N(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_dm(req_dm),
        .wdata_pop(wdata_pop), .rd_data(rd_data), .rd_valid(rd_valid),
        .CMD(cmd), .ADDR(addr), .CMDACK(cmdack),
        .DATAIN(datain), .DM(dm), .DATAOUT(dataout),
        .busy(busy), .ref_overrun(ref_overrun)
    );

    ddr_host_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW),
        .BURST_LEN(2), .RD_LAT(4), .REF_PERIOD(20)
    ) u_ref (
        .CLK(clk), .RESET_N(r_rst_n),
        .req_valid(r_req_valid), .req_ready(r_req_ready),
        .req_cmd(r_req_cmd), .req_addr(r_req_addr),
        .req_wdata(r_req_wdata), .req_dm(r_req_dm),
        .wdata_pop(r_wdata_pop), .rd_data(r_rd_data), .rd_valid(r_rd_valid),
        .CMD(r_cmd), .ADDR(r_addr), .CMDACK(r_cmdack),
        .DATAIN(r_datain), .DM(r_dm), .DATAOUT(r_dataout),
        .busy(r_busy), .ref_overrun(r_ref_overrun)
    );

    task automatic test_reset();
        rst_n = 1'b0; r_rst_n = 1'b0;
        req_valid = 2'b11; req_cmd = 6'b010_010;
        req_addr = '0; req_wdata = '0; req_dm = '0;
        cmdack = 1'b0; dataout = '0;
        r_req_valid = '0; r_req_cmd = 6'b010_010;
        r_req_addr = '0; r_req_wdata = '0; r_req_dm = '0;
        r_cmdack = 1'b0; r_dataout = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({cmd, addr, datain, dm} !== '0) begin
            n_fail++;
            $display("FAIL rst_bus got cmd=%h addr=%h din=%h dm=%h exp 0", cmd, addr, datain, dm);
        end
        n_cmp++;
        if ({req_ready, wdata_pop, rd_valid, busy, ref_overrun} !== '0) begin
            n_fail++;
            $display("FAIL rst_ctl got rdy=%b pop=%b rv=%b busy=%b ovr=%b exp 0",
                     req_ready, wdata_pop, rd_valid, busy, ref_overrun);
        end
        n_cmp++;
        if (rd_data !== '0) begin
            n_fail++;
            $display("FAIL rst_rdata got %h exp 0", rd_data);
        end
        req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_busy got %b exp 0", busy);
        end
    endtask

    task automatic test_write();
        req_cmd[2:0] = 3'b010; req_addr[AW-1:0] = 23'h10;
        req_wdata[DW-1:0] = B0; req_wdata[2*DW-1:DW] = BX;
        req_dm[MW-1:0] = 16'h0F0F; req_dm[2*MW-1:MW] = 16'hFFFF;
        req_valid = 2'b01;
        @(negedge clk);
        n_cmp++;
        if ({cmd, addr, req_ready, busy} !== {3'b010, 23'h10, 2'b01, 1'b1}) begin
            n_fail++;
            $display("FAIL wr_issue got cmd=%h addr=%h rdy=%b busy=%b exp 2/10/01/1",
                     cmd, addr, req_ready, busy);
        end
        req_valid = 2'b00;
        @(negedge clk);
        n_cmp++;
        if ({cmd, req_ready} !== {3'b010, 2'b00}) begin
            n_fail++;
            $display("FAIL wr_hold got cmd=%h rdy=%b exp 2/00", cmd, req_ready);
        end
        cmdack = 1'b1;
        @(negedge clk);
        cmdack = 1'b0;
        n_cmp++;
        if ({cmd, wdata_pop, datain, dm} !== {3'b000, 2'b01, B0, 16'h0F0F}) begin
            n_fail++;
            $display("FAIL wr_beat0 got cmd=%h pop=%b din=%h dm=%h", cmd, wdata_pop, datain, dm);
        end
        req_wdata[DW-1:0] = B1;
        @(negedge clk);
        n_cmp++;
        if ({wdata_pop, datain} !== {2'b01, B1}) begin
            n_fail++;
            $display("FAIL wr_beat1 got pop=%b din=%h exp 01/%h", wdata_pop, datain, B1);
        end
        @(negedge clk);
        n_cmp++;
        if ({wdata_pop, datain, dm, busy} !== {2'b00, {DW{1'b0}}, 16'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL wr_done got pop=%b din=%h dm=%h busy=%b", wdata_pop, datain, dm, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_idle got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_read();
        req_cmd[2:0] = 3'b001; req_addr[AW-1:0] = 23'h20;
        req_valid = 2'b01; dataout = 128'hDEAD;
        @(negedge clk);
        n_cmp++;
        if ({cmd, addr} !== {3'b001, 23'h20}) begin
            n_fail++;
            $display("FAIL rd_issue got cmd=%h addr=%h exp 1/20", cmd, addr);
        end
        req_valid = 2'b00; cmdack = 1'b1;
        @(negedge clk);
        cmdack = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rd_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL rd_early got rv=%b exp 00", rd_valid);
        end
        dataout = 128'hA;
        @(negedge clk);
        n_cmp++;
        if ({rd_valid, rd_data} !== {2'b01, 128'hA}) begin
            n_fail++;
            $display("FAIL rd_beat0 got rv=%b data=%h exp 01/a", rd_valid, rd_data);
        end
        dataout = 128'hB;
        @(negedge clk);
        n_cmp++;
        if ({rd_valid, rd_data} !== {2'b01, 128'hB}) begin
            n_fail++;
            $display("FAIL rd_beat1 got rv=%b data=%h exp 01/b", rd_valid, rd_data);
        end
        dataout = 128'hDEAD;
        @(negedge clk);
        n_cmp++;
        if ({rd_valid, busy} !== {2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL rd_end got rv=%b busy=%b exp 00/0", rd_valid, busy);
        end
    endtask

    task automatic test_illegal();
        req_cmd[2:0] = 3'b100; req_valid = 2'b01;
        @(negedge clk);
        n_cmp++;
        if ({req_ready, cmd, busy} !== {2'b01, 3'b000, 1'b1}) begin
            n_fail++;
            $display("FAIL ill_grant got rdy=%b cmd=%h busy=%b exp 01/0/1", req_ready, cmd, busy);
        end
        req_valid = 2'b00;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ill_done got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_reset_mid_write();
        req_cmd = 6'b010_010; req_addr[AW-1:0] = 23'h10;
        req_addr[2*AW-1:AW] = 23'h55;
        req_wdata[DW-1:0] = B0; req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00; cmdack = 1'b1;
        @(negedge clk);
        cmdack = 1'b0;
        n_cmp++;
        if (wdata_pop !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_pre got pop=%b exp 01", wdata_pop);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({cmd, datain, wdata_pop, busy} !== '0) begin
            n_fail++;
            $display("FAIL mid_abort got cmd=%h din=%h pop=%b busy=%b exp 0",
                     cmd, datain, wdata_pop, busy);
        end
        req_valid = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({req_ready, addr} !== {2'b01, 23'h10}) begin
            n_fail++;
            $display("FAIL mid_regrant got rdy=%b addr=%h exp 01/10", req_ready, addr);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_round_robin();
        int got;
        int order [4];
        int exp_order [4] = '{0, 1, 0, 1};
        got = 0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; req_cmd = 6'b010_010; req_valid = 2'b11;
        for (int i = 0; i < 80 && got < 4; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                order[got] = (req_ready == 2'b01) ? 0 : (req_ready == 2'b10) ? 1 : 9;
                got++;
            end
            cmdack = (cmd != 3'b000);
        end
        req_valid = 2'b00;
        n_cmp++;
        if (got !== 4) begin
            n_fail++;
            $display("FAIL rr_timeout got %0d grants exp 4", got);
        end
        for (int i = 0; i < got; i++) begin
            n_cmp++;
            if (order[i] !== exp_order[i]) begin
                n_fail++;
                $display("FAIL rr_order[%0d] got %0d exp %0d", i, order[i], exp_order[i]);
            end
        end
        repeat (10) begin
            @(negedge clk);
            cmdack = (cmd != 3'b000);
        end
        cmdack = 1'b0;
    endtask

    task automatic test_refresh();
        int grants, grants_before, ref_at, post_grant;
        grants = 0; grants_before = -1; ref_at = -1; post_grant = -1;
        r_rst_n = 1'b1; r_req_cmd[2:0] = 3'b010; r_req_valid = 2'b01;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (r_cmd == 3'b011 && ref_at < 0) begin
                ref_at = k;
                grants_before = grants;
            end
            if (r_req_ready != 2'b00) begin
                grants++;
                if (ref_at > 0 && post_grant < 0)
                    post_grant = (r_req_ready == 2'b01) ? k : -2;
            end
            r_cmdack = (r_cmd != 3'b000);
        end
        r_req_valid = 2'b00; r_cmdack = 1'b0;
        n_cmp++;
        if (ref_at !== 21) begin
            n_fail++;
            $display("FAIL ref_cycle got %0d exp 21", ref_at);
        end
        n_cmp++;
        if (grants_before !== 4) begin
            n_fail++;
            $display("FAIL ref_grants_before got %0d exp 4", grants_before);
        end
        n_cmp++;
        if (post_grant !== 24) begin
            n_fail++;
            $display("FAIL ref_resume got %0d exp 24", post_grant);
        end
        n_cmp++;
        if (r_ref_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ref_no_ovr got %b exp 0", r_ref_overrun);
        end
    endtask

    task automatic test_overrun();
        r_rst_n = 1'b0;
        @(negedge clk);
        r_rst_n = 1'b1; r_req_valid = 2'b00; r_cmdack = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k == 21 || k == 45) begin
                n_cmp++;
                if (r_cmd !== 3'b011) begin
                    n_fail++;
                    $display("FAIL ovr_refcmd@%0d got %h exp 3", k, r_cmd);
                end
            end
            if (k == 39) begin
                n_cmp++;
                if (r_ref_overrun !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovr_early got %b exp 0", r_ref_overrun);
                end
            end
            if (k == 40) begin
                n_cmp++;
                if (r_ref_overrun !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ovr_set got %b exp 1", r_ref_overrun);
                end
            end
            r_cmdack = (k == 66);
        end
        n_cmp++;
        if ({r_ref_overrun, r_busy, r_cmd} !== {1'b1, 1'b0, 3'b000}) begin
            n_fail++;
            $display("FAIL ovr_sticky got ovr=%b busy=%b cmd=%h exp 1/0/0",
                     r_ref_overrun, r_busy, r_cmd);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_illegal();
        test_reset_mid_write();
        test_round_robin();
        test_refresh();
        test_overrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_host_arbiter.md
Name: ddr_host_arbiter

Overview:
- Shares the single host-side command port of the DDR SDRAM controller (CMD/ADDR/CMDACK/DATAIN/DATAOUT/DM) between NUM_REQ requesters.
- Arbitrates round-robin, drives one command at a time and holds it until CMDACK.
- Sequences the write-data and read-data windows, and routes read data back to the owning requester.
- Schedules auto-refresh from an internal interval counter; refresh takes priority over requesters.

Parameters:
- NUM_REQ, 2, number of requesters (2..4)
- ADDR_W, 23, host address width
- DATA_W, 128, host data width; DM width is DATA_W/8
- BURST_LEN, 2, host data beats per read/write command
- RD_LAT, 4, cycles from CMDACK to first valid read beat on DATAOUT
- REF_PERIOD, 1560, cycles between refresh requests (16-bit counter)

Ports:
- CLK  in  1  clock
- RESET_N  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  request present, one bit per requester
- req_ready  out  NUM_REQ  request accepted (one-cycle pulse)
- req_cmd  in  3*NUM_REQ  per-requester command; only READA/WRITEA legal
- req_addr  in  ADDR_W*NUM_REQ  per-requester address
- req_wdata  in  DATA_W*NUM_REQ  per-requester write data beat
- req_dm  in  (DATA_W/8)*NUM_REQ  per-requester byte mask
- wdata_pop  out  NUM_REQ  beat consumed; requester advances to next beat
- rd_data  out  DATA_W  read data, shared bus
- rd_valid  out  NUM_REQ  read beat valid for that requester
- CMD  out  3  to controller
- ADDR  out  ADDR_W  to controller
- CMDACK  in  1  from controller
- DATAIN  out  DATA_W  to controller
- DM  out  DATA_W/8  to controller
- DATAOUT  in  DATA_W  from controller
- busy  out  1  FSM not in IDLE
- ref_overrun  out  1  sticky; refresh interval expired while a refresh was still pending

Behaviour:
- Reset: all outputs 0. CMD=NOP. FSM=IDLE. rr pointer=0. Refresh counter=REF_PERIOD-1. ref_pending=0.

Refresh counter:
- Decrements every cycle. At 0 it reloads REF_PERIOD-1 and sets ref_pending.
- If ref_pending is already 1 at expiry, ref_overrun sets. It clears only on reset.

FSM states:
- IDLE:
  - If ref_pending -> REF_ISSUE.
  - Else if any req_valid -> pick the first valid index at or after rr pointer, modulo NUM_REQ.
  - Latch owner, cmd, addr. Pulse req_ready[owner] for one cycle. Go to CMD_ISSUE.
  - Arbitration decision is combinational on IDLE-cycle inputs. req_ready is registered, so the pulse appears in the cycle CMD_ISSUE is entered.
- CMD_ISSUE:
  - CMD = latched cmd, ADDR = latched addr, held stable until CMDACK=1.
  - On CMDACK, CMD returns to NOP the next cycle and a beat counter clears.
  - WRITEA -> WR_DATA. READA -> RD_WAIT.
- WR_DATA:
  - BURST_LEN cycles. DATAIN/DM = owner's req_wdata/req_dm. wdata_pop[owner]=1 each cycle.
  - After the last beat -> DONE.
- RD_WAIT:
  - Counts RD_LAT-1 cycles after the CMDACK cycle -> RD_DATA.
- RD_DATA:
  - BURST_LEN cycles. rd_data=DATAOUT registered, rd_valid[owner] registered.
  - First rd_valid therefore comes RD_LAT+1 cycles after CMDACK.
  - -> DONE.
- REF_ISSUE:
  - CMD=REFRESH (3'b011) until CMDACK. ref_pending clears on CMDACK. -> DONE.
  - A counter expiry in the same cycle as CMDACK re-sets ref_pending; set wins.
- DONE:
  - One idle cycle with CMD=NOP, giving a bus turnaround.
  - rr pointer = owner+1 mod NUM_REQ (unchanged after a refresh). -> IDLE.

Boundary and error cases:
- An illegal req_cmd (not READA/WRITEA) is still granted but completes as NOP: CMD_ISSUE is skipped and the FSM goes to DONE.
- Starvation bound: a requester waits at most NUM_REQ-1 transactions plus one refresh.
- DATAIN and DM are 0 outside WR_DATA. rd_valid is 0 outside RD_DATA.
- Async reset mid-transaction aborts immediately to reset values. No replay.

Decomposition:
- Package ddr_pkg holds:
  - cmd_e enum: NOP=000, READA=001, WRITEA=010, REFRESH=011, PRECHARGE=100, LOAD_MODE=101, LOAD_REG1=110, LOAD_REG2=111.
  - arb_state_e enum: IDLE, CMD_ISSUE, WR_DATA, RD_WAIT, RD_DATA, REF_ISSUE, DONE.
- One sub-module, ddr_rr_arbiter:
  - Combinational pick of the winning index from req_valid and the rr pointer.
  - Outputs one-hot grant and a found flag.

Test Plan:
- REF_PERIOD=1000; req0 valid, WRITEA addr 0x10, CMDACK 2 cycles after CMD -> CMD=010 held 2 cycles, then 2 wdata_pop[0] cycles with DATAIN=beats; busy clears 1 cycle after DONE.
- req0 READA addr 0x20, CMDACK after 1 cycle, DATAOUT=0xA,0xB at CMDACK+4,+5 -> rd_valid[0] at CMDACK+5,+6 with rd_data 0xA,0xB; rd_valid[1]=0.
- req0 and req1 continuously valid, 4 transactions -> grant order 0,1,0,1.
- REF_PERIOD=20 with req0 always valid -> REFRESH (011) issued before the next grant after expiry; ref_pending clears on CMDACK.
- REF_PERIOD=20, CMDACK withheld 45 cycles during REFRESH -> ref_overrun=1 and stays 1.
- Deassert RESET_N during WR_DATA -> CMD=NOP, DATAIN=0, wdata_pop=0 immediately; after release req0 is granted first.
